// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices MSB-first and stops at the first
// differing slice. Signed compares flip the operand sign bits so an unsigned walk gives the order.
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             busy_q, done_q, eq_q, gt_q, lt_q;
  logic [CHUNK-1:0] a_chunk, b_chunk;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_q     <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
            b_q     <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
            idx_q   <= IdxLast;
            state_q <= StBusy;
            busy_q  <= 1'b1;
          end
        end
        StBusy: begin
          if (a_chunk != b_chunk) begin
            gt_q    <= (a_chunk > b_chunk);
            lt_q    <= (a_chunk < b_chunk);
            eq_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4): vector table plus
// hand-written sequences for busy-start, back-to-back and mid-compare reset.
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, eq, gt, lt;

  int n_cmp = 0;
  int n_bad = 0;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .eq          (eq),
    .gt          (gt),
    .lt          (lt)
  );

  always #5 clk = ~clk;

  // Result encoding used by the table: {eq, gt, lt}.
  localparam logic [2:0] REq = 3'b100;
  localparam logic [2:0] RGt = 3'b010;
  localparam logic [2:0] RLt = 3'b001;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sm;
    int               k;
    logic [2:0]       res;
  } vec_t;

  vec_t       vecs[10];
  logic [2:0] prev_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Drive a start at the falling edge; returns 1ns after the accepting edge T0.
  task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic sm);
    @(negedge clk);
    a = va;
    b = vb;
    signed_mode = sm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done with a cycle budget; lat = edges after T0, or -1 on timeout.
  // Also checks that the previous result is held while the compare runs.
  task automatic wait_done(input string name, input logic [2:0] held, output int lat);
    bit found;
    found = 1'b0;
    lat = -1;
    for (int c = 1; c <= N + 2; c++) begin
      if (!found) begin
        @(posedge clk);
        #1;
        if (done) begin
          found = 1'b1;
          lat = c;
        end else if (c == 1) begin
          chk({name, " busy_mid"}, {31'd0, busy}, 32'd1);
          chk({name, " held"}, {29'd0, eq, gt, lt}, {29'd0, held});
        end
      end
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no done within %0d cycles", name, N + 2);
    end
  endtask

  initial begin
    int lat;
    int dones;

    vecs[0] = '{16'h1234, 16'h1234, 1'b0, 4, REq};
    vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 1, RGt};
    vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 1, RLt};
    vecs[3] = '{16'h1234, 16'h1235, 1'b0, 4, RLt};
    vecs[4] = '{16'hFFFF, 16'hFFFE, 1'b1, 4, RGt};
    vecs[5] = '{16'h0100, 16'h00FF, 1'b0, 2, RGt};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 4, REq};
    vecs[7] = '{16'h1200, 16'h1300, 1'b0, 2, RLt};
    vecs[8] = '{16'hFFFF, 16'h0001, 1'b1, 1, RLt};
    vecs[9] = '{16'h00A0, 16'h00B0, 1'b0, 3, RLt};

    // Reset state, during and after reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in outs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out outs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    prev_res = 3'b000;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sm);
      chk($sformatf("v%0d busy_t0", i), {30'd0, busy, done}, 32'd2);
      wait_done($sformatf("v%0d", i), prev_res, lat);
      if (lat >= 0) begin
        chk($sformatf("v%0d latency", i), lat, vecs[i].k);
        chk($sformatf("v%0d result", i), {29'd0, eq, gt, lt}, {29'd0, vecs[i].res});
        chk($sformatf("v%0d busy_at_done", i), {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d done_pulse", i), {31'd0, done}, 32'd0);
      end
      prev_res = vecs[i].res;
    end

    // Start held while busy with changing operands: captured zeros must win.
    launch(16'h0000, 16'h0000, 1'b0);
    dones = 0;
    lat = -1;
    for (int c = 1; c <= N + 6; c++) begin
      if (c < N) begin
        start = 1'b1;
        a = 16'hFFFF;
        b = 16'(c * 16'h1357);
        signed_mode = c[0];
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (lat < 0) begin
          lat = c;
          chk("busy_start result", {29'd0, eq, gt, lt}, {29'd0, REq});
        end
      end
    end
    start = 1'b0;
    chk("busy_start latency", lat, N);
    chk("busy_start done_count", dones, 1);

    // Back-to-back: start accepted in the done cycle of a prior lt result.
    launch(16'h0000, 16'h0001, 1'b0);
    lat = -1;
    for (int c = 1; c <= N + 2; c++) begin
      if (lat < 0) begin
        @(posedge clk);
        #1;
        if (done) lat = c;
      end
    end
    chk("b2b first latency", lat, N);
    chk("b2b first result", {29'd0, eq, gt, lt}, {29'd0, RLt});
    a = 16'h0001;
    b = 16'h0000;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b accepted busy", {30'd0, busy, done}, 32'd2);
    wait_done("b2b second", RLt, lat);
    chk("b2b second latency", lat, N);
    chk("b2b second result", {29'd0, eq, gt, lt}, {29'd0, RGt});

    // Reset mid-compare aborts and clears results.
    launch(16'h1111, 16'h1112, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst outs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < N + 4; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    chk("midrst quiet", dones, 0);

    // Fresh compare after the abort.
    launch(16'h1111, 16'h1112, 1'b0);
    wait_done("post_rst", 3'b000, lat);
    chk("post_rst latency", lat, N);
    chk("post_rst result", {29'd0, eq, gt, lt}, {29'd0, RLt});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Multi-cycle, parametrised magnitude comparator that compares two WIDTH-bit operands CHUNK bits per clock, MSB-first, and terminates early at the first differing chunk. It supports runtime-selectable signed or unsigned comparison and reports exactly one of eq/gt/lt with a one-cycle done pulse. It replaces single-cycle 4-bit comparators on datapaths where operand width makes a flat compare timing-critical.

## Interface

Parameters:
- WIDTH, default 16: operand width in bits; must be a multiple of CHUNK and at least 2.
- CHUNK, default 4: bits compared per cycle; N = WIDTH/CHUNK chunks.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only while idle.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured on accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when a result is written.
- eq  output  1  a == b (registered, held).
- gt  output  1  a > b (registered, held).
- lt  output  1  a < b (registered, held).

## Operation

- States: IDLE, BUSY. Chunk index idx has a width of ceil(log2(N)), minimum 1 bit.
- IDLE with start=1:
  - Capture a, b and signed_mode into internal registers.
  - In signed mode, invert bit WIDTH-1 of both captured operands. An unsigned compare of the adjusted values then gives the signed order.
  - Set idx = N-1, go to BUSY, set busy=1.
- BUSY, each cycle: compare chunk idx of A against chunk idx of B as unsigned values.
  - Chunks differ: set gt = (A chunk > B chunk), lt = the inverse of gt, eq=0, done=1. Go to IDLE, busy=0.
  - Chunks equal and idx==0: set eq=1, gt=0, lt=0, done=1. Go to IDLE, busy=0.
  - Chunks equal and idx>0: decrement idx and stay in BUSY.
- start is ignored while BUSY. Operands, mode and the compare in progress are unaffected.
- a, b and signed_mode may change freely after capture; only the captured copies are used.
- eq/gt/lt hold their last result until the next result is written. They do not change when start is accepted.
- After the first result, exactly one of eq/gt/lt is high.

## Timing

- Reset: while rst_n=0 and immediately after release, state=IDLE, idx=0, and busy=done=eq=gt=lt=0.
- Reset asserted mid-compare aborts it. No done is issued and previous results are cleared to 0.
- Latency is measured from the edge that accepts start (edge T0). The result and done=1 are visible after edge T0+k, where k is the number of chunks examined (1 ≤ k ≤ N). Worst case (equal operands, or a difference only in chunk 0) is N cycles.
- busy is high from after T0 until after the edge that writes the result. It is low in the same cycle that done is high.
- done is high for exactly one cycle per accepted start.
- Back-to-back: start=1 during the done cycle is accepted, because the block is in IDLE. No idle bubble is required.
- Equal-width rule: no carry or subtraction is used; chunks are compared as unsigned CHUNK-bit values only.

## Test plan

All scenarios use WIDTH=16, CHUNK=4.

- Equal operands: a=16'h1234, b=16'h1234, unsigned, pulse start → busy for 4 cycles; done after T0+4; eq=1, gt=0, lt=0.
- Early exit: a=16'h8000, b=16'h7FFF, unsigned → done after T0+1; gt=1. Same operands with signed_mode=1 → done after T0+1; lt=1.
- Late difference and signed negatives:
  - a=16'h1234, b=16'h1235, unsigned → done after T0+4; lt=1.
  - a=16'hFFFF, b=16'hFFFE, signed → done after T0+4; gt=1, since -1 > -2.
- Start while busy: start a=0x0000/b=0x0000. While busy, drive start=1 with a=0xFFFF and change a/b every cycle → exactly one done after T0+4; eq=1, because the captured operands are used.
- Back-to-back: assert start in the done cycle with a=16'h0001, b=16'h0000 → accepted; next done after 4 more cycles with gt=1; eq/gt/lt hold the prior result until then.
- Reset mid-op: start a=16'h1111, b=16'h1112, then drop rst_n at T0+2 → busy, done, eq, gt and lt are all 0 immediately. After release, no done appears until a new start is given.
